integral_row_feeder: RTL and testbench
======================================

Name: integral_row_feeder

Overview:
- Writer-side front end for the integral-image row line buffers: takes a pixel stream from image memory (valid/ready) and drives the row buffer write port (o_wen, o_fifo_in).
- Tracks the raster position of each pixel, marks end-of-row, and at frame end writes zero-valued flush pixels so every row buffer drains its last pixels.
- Sits between the frame source and the first row stage of the integral-image chain.

Parameters:
- DATA_WIDTH, 8, pixel width; matches the row buffer data width.
- FRAME_WIDTH, 10, pixels per image row (minimum 2).
- FRAME_HEIGHT, 10, rows per frame (minimum 1).
- COL_WIDTH, 10, column counter width; must satisfy 2**COL_WIDTH >= FRAME_WIDTH.
- ROW_WIDTH, 10, row counter width; must satisfy 2**ROW_WIDTH >= FRAME_HEIGHT.
- FLUSH_COUNT, 6, zero pixels written after the last frame pixel; equals the row buffer depth (FIFO_COMPONENT_COUNT).

Ports:
- clk_os, in, 1, system clock; all logic on rising edge.
- reset_os, in, 1, asynchronous, active-high reset.
- i_start, in, 1, single-cycle frame start request; sampled only in IDLE.
- i_pixel_valid, in, 1, source has a pixel on i_pixel_data.
- i_pixel_data, in, DATA_WIDTH, pixel value.
- o_pixel_ready, out, 1, feeder accepts a pixel this cycle.
- o_wen, out, 1, row buffer write enable.
- o_fifo_in, out, DATA_WIDTH, row buffer write data.
- o_col_index, out, COL_WIDTH, column of the pixel currently on o_fifo_in.
- o_row_index, out, ROW_WIDTH, row of the pixel currently on o_fifo_in.
- o_end_of_row, out, 1, high with o_wen for the last pixel of each row.
- o_busy, out, 1, high in FEED and FLUSH.
- o_frame_done, out, 1, one-cycle pulse when the frame and its flush are complete.

Behaviour:
- Reset: state=IDLE. o_pixel_ready, o_wen, o_end_of_row, o_busy and o_frame_done are 0. o_fifo_in, o_col_index and o_row_index are 0. Internal column and row counters are 0.
- Accept condition: a pixel is accepted when i_pixel_valid && o_pixel_ready.
- o_pixel_ready is combinational from state: 1 only in FEED.
- Latency: an accepted pixel appears registered on o_fifo_in the next cycle, with o_wen=1 and position tags.
- If no pixel is accepted in a cycle, o_wen=0 the next cycle and o_fifo_in holds its last value.
- IDLE: if i_start=1, clear the counters and go to FEED. Otherwise stay in IDLE.
- FEED:
  - On accept, col++.
  - If col==FRAME_WIDTH-1, col wraps to 0, row++, and the registered output carries o_end_of_row=1.
  - If col==FRAME_WIDTH-1 && row==FRAME_HEIGHT-1, go to FLUSH and load the flush counter with FLUSH_COUNT.
  - i_start is ignored while busy.
- FLUSH:
  - o_wen=1 every cycle with o_fifo_in=0, for exactly FLUSH_COUNT cycles.
  - o_end_of_row=0 during flush.
  - Position outputs hold the last real pixel's tags.
  - Decrement the counter each cycle; at 1 go to DONE.
  - If FLUSH_COUNT==0, go from the last accept straight to DONE.
- DONE: o_frame_done=1 for one cycle, o_busy=0, then go to IDLE.
- Simultaneous events: the last-pixel accept and the FLUSH entry occur on the same edge. The first flush write immediately follows the last pixel write with no gap.
- Reset mid-operation: asynchronous return to the reset values. Partial frame is discarded; no o_frame_done.
- Counter widths: compare against the parameters at full width; no modulo-2**N wrap is relied on.

Optional Feature:
- Macro: INTEGRAL_ROW_FEEDER_ABORT_EN.
- With macro: adds input i_abort (1 bit) and output o_aborted (1 bit, reset 0).
  - i_abort=1 in FEED or FLUSH causes a synchronous return to IDLE on the next edge.
  - o_wen=0 from that edge; counters are cleared.
  - o_aborted pulses for one cycle; no o_frame_done.
  - i_abort in IDLE or DONE is ignored.
  - If i_abort coincides with an accept, the pixel is not written.
- Without macro: ports are absent; the FSM is exactly as above.

Decomposition:
- Package integral_feeder_pkg holds:
  - state encoding typedef (IDLE=2'd0, FEED=2'd1, FLUSH=2'd2, DONE=2'd3);
  - default width constants;
  - a function computing the counter width from a dimension.
- One sub-module, frame_position_counter: col/row counters with an increment enable, synchronous clear, wrap at FRAME_WIDTH-1, and last_col/last_pixel flags.

Test Plan (FRAME_WIDTH=4, FRAME_HEIGHT=2, FLUSH_COUNT=3, DATA_WIDTH=8):
- Reset then idle with i_pixel_valid=1 and no start -> o_pixel_ready=0 and o_wen=0 for 20 cycles.
- i_start, then pixels 1..8 with valid held high -> o_wen high 8 cycles with o_fifo_in=1..8, each 1 cycle after accept. o_end_of_row on values 4 and 8. Row tags 0,0,0,0,1,1,1,1. Then 3 writes of 0, then o_frame_done for 1 cycle.
- Valid toggled 1,0,1,0 through the frame -> o_wen gaps mirror the gaps exactly. Data order is preserved and the total is 8 pixel writes plus 3 flush writes.
- i_start pulsed again mid-frame after pixel 3 -> ignored; counters continue and the frame completes normally.
- reset_os asserted mid-FLUSH, asynchronously and between edges -> all outputs 0 immediately. No o_frame_done. A new i_start then streams a full frame correctly.
- With INTEGRAL_ROW_FEEDER_ABORT_EN, i_abort together with the accept of pixel 5 -> pixel 5 is not written, o_aborted pulses, state returns to IDLE, and o_frame_done never asserts.

Source files
------------

// File: rtl/integral_feeder_pkg.sv
// Shared state encoding, default widths and counter-width helper for the
// integral-image row feeder.
package integral_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } feeder_state_t;

   localparam int DEF_DATA_WIDTH   = 8;
   localparam int DEF_FRAME_WIDTH  = 10;
   localparam int DEF_FRAME_HEIGHT = 10;
   localparam int DEF_COL_WIDTH    = 10;
   localparam int DEF_ROW_WIDTH    = 10;
   localparam int DEF_FLUSH_COUNT  = 6;

   // Smallest width (at least 1) able to hold every value in 0..dim-1.
   function automatic int cnt_width(input int dim);
      int w;
      w = 1;
      while (((1 << w) < dim) && (w < 31)) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/frame_position_counter.sv
// Raster column/row tracker: advances one pixel per increment, wraps the column
// at the end of each row and flags the last column and the last frame pixel.
module frame_position_counter
   import integral_feeder_pkg::*;
#(
   parameter int FRAME_WIDTH  = DEF_FRAME_WIDTH,
   parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
   parameter int COL_WIDTH    = DEF_COL_WIDTH,
   parameter int ROW_WIDTH    = DEF_ROW_WIDTH
) (
   input  logic                 clk_os,
   input  logic                 reset_os,
   input  logic                 clr_i,
   input  logic                 inc_i,
   output logic [COL_WIDTH-1:0] col_o,
   output logic [ROW_WIDTH-1:0] row_o,
   output logic                 last_col_o,
   output logic                 last_pixel_o
);

   logic [COL_WIDTH-1:0] col_q, col_d;
   logic [ROW_WIDTH-1:0] row_q, row_d;

   // Compared as int so no truncation of the frame dimensions is involved.
   assign last_col_o   = (int'(col_q) == FRAME_WIDTH - 1);
   assign last_pixel_o = last_col_o && (int'(row_q) == FRAME_HEIGHT - 1);
   assign col_o        = col_q;
   assign row_o        = row_q;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr_i) begin
         col_d = '0;
         row_d = '0;
      end else if (inc_i) begin
         if (last_pixel_o) begin
            col_d = '0;
            row_d = '0;
         end else if (last_col_o) begin
            col_d = '0;
            row_d = row_q + ROW_WIDTH'(1);
         end else begin
            col_d = col_q + COL_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_os or posedge reset_os) begin
      if (reset_os) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/integral_row_feeder.sv
// Writer-side front end of the integral-image row buffers: tags each pixel with its
// raster position and drains the buffers with zero pixels at frame end.
// Optional abort port pair enabled by defining INTEGRAL_ROW_FEEDER_ABORT_EN.
module integral_row_feeder
   import integral_feeder_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int FRAME_WIDTH  = DEF_FRAME_WIDTH,
   parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
   parameter int COL_WIDTH    = DEF_COL_WIDTH,
   parameter int ROW_WIDTH    = DEF_ROW_WIDTH,
   parameter int FLUSH_COUNT  = DEF_FLUSH_COUNT
) (
   input  logic                  clk_os,
   input  logic                  reset_os,
   input  logic                  i_start,
   input  logic                  i_pixel_valid,
   input  logic [DATA_WIDTH-1:0] i_pixel_data,
   output logic                  o_pixel_ready,
   output logic                  o_wen,
   output logic [DATA_WIDTH-1:0] o_fifo_in,
   output logic [COL_WIDTH-1:0]  o_col_index,
   output logic [ROW_WIDTH-1:0]  o_row_index,
   output logic                  o_end_of_row,
   output logic                  o_busy,
`ifdef INTEGRAL_ROW_FEEDER_ABORT_EN
   input  logic                  i_abort,
   output logic                  o_aborted,
`endif
   output logic                  o_frame_done
);

   localparam int FLUSH_W = cnt_width(FLUSH_COUNT + 1);

   feeder_state_t         state_q, state_d;
   logic [FLUSH_W-1:0]    flush_q, flush_d;
   logic                  wen_q, wen_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [COL_WIDTH-1:0]  col_q, col_d;
   logic [ROW_WIDTH-1:0]  row_q, row_d;
   logic                  eor_q, eor_d;
   logic                  done_q, done_d;
`ifdef INTEGRAL_ROW_FEEDER_ABORT_EN
   logic                  aborted_q, aborted_d;
`endif

   logic                  accept;
   logic                  cnt_clr, cnt_inc;
   logic [COL_WIDTH-1:0]  cur_col;
   logic [ROW_WIDTH-1:0]  cur_row;
   logic                  last_col, last_pixel;

   frame_position_counter #(
      .FRAME_WIDTH (FRAME_WIDTH),
      .FRAME_HEIGHT(FRAME_HEIGHT),
      .COL_WIDTH   (COL_WIDTH),
      .ROW_WIDTH   (ROW_WIDTH)
   ) u_pos (
      .clk_os      (clk_os),
      .reset_os    (reset_os),
      .clr_i       (cnt_clr),
      .inc_i       (cnt_inc),
      .col_o       (cur_col),
      .row_o       (cur_row),
      .last_col_o  (last_col),
      .last_pixel_o(last_pixel)
   );

   assign o_pixel_ready = (state_q == FEED);
   assign accept        = i_pixel_valid && o_pixel_ready;

   always_comb begin
      state_d = state_q;
      flush_d = flush_q;
      wen_d   = 1'b0;
      data_d  = data_q;
      col_d   = col_q;
      row_d   = row_q;
      eor_d   = 1'b0;
      done_d  = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
`ifdef INTEGRAL_ROW_FEEDER_ABORT_EN
      aborted_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (i_start) begin
               cnt_clr = 1'b1;
               state_d = FEED;
            end
         end
         FEED: begin
            if (accept) begin
               cnt_inc = 1'b1;
               wen_d   = 1'b1;
               data_d  = i_pixel_data;
               col_d   = cur_col;
               row_d   = cur_row;
               eor_d   = last_col;
               if (last_pixel) begin
                  if (FLUSH_COUNT == 0) begin
                     state_d = DONE;
                  end else begin
                     state_d = FLUSH;
                     flush_d = FLUSH_W'(FLUSH_COUNT);
                  end
               end
            end
         end
         FLUSH: begin
            // Position tags keep the last real pixel's values while zeros drain out.
            wen_d   = 1'b1;
            data_d  = '0;
            flush_d = flush_q - FLUSH_W'(1);
            if (flush_q <= FLUSH_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
`ifdef INTEGRAL_ROW_FEEDER_ABORT_EN
      // Abort wins over a coinciding accept: that pixel is dropped, not written.
      if (i_abort && (state_q == FEED || state_q == FLUSH)) begin
         state_d   = IDLE;
         flush_d   = '0;
         wen_d     = 1'b0;
         data_d    = data_q;
         col_d     = col_q;
         row_d     = row_q;
         eor_d     = 1'b0;
         cnt_inc   = 1'b0;
         cnt_clr   = 1'b1;
         aborted_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk_os or posedge reset_os) begin
      if (reset_os) begin
         state_q <= IDLE;
         flush_q <= '0;
         wen_q   <= 1'b0;
         data_q  <= '0;
         col_q   <= '0;
         row_q   <= '0;
         eor_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         flush_q <= flush_d;
         wen_q   <= wen_d;
         data_q  <= data_d;
         col_q   <= col_d;
         row_q   <= row_d;
         eor_q   <= eor_d;
         done_q  <= done_d;
      end
   end

`ifdef INTEGRAL_ROW_FEEDER_ABORT_EN
   always_ff @(posedge clk_os or posedge reset_os) begin
      if (reset_os) begin
         aborted_q <= 1'b0;
      end else begin
         aborted_q <= aborted_d;
      end
   end

   assign o_aborted = aborted_q;
`endif

   assign o_wen        = wen_q;
   assign o_fifo_in    = data_q;
   assign o_col_index  = col_q;
   assign o_row_index  = row_q;
   assign o_end_of_row = eor_q;
   assign o_busy       = (state_q == FEED) || (state_q == FLUSH);
   assign o_frame_done = done_q;

endmodule

// File: tb/tb_integral_row_feeder.sv
// Randomised bench for integral_row_feeder: a frame-level model predicts the write
// stream, its timing and the frame-done pulse from the accepted pixels.
module tb_integral_row_feeder;

   localparam int DW     = 8;
   localparam int FW     = 4;
   localparam int FH     = 2;
   localparam int FC     = 3;
   localparam int CW     = 10;
   localparam int RW     = 10;
   localparam int NPIX   = FW * FH;
   localparam int BUDGET = 200;

   typedef struct {
      logic [DW-1:0] d;
      int            c;
      int            r;
      bit            e;
   } wr_t;

   logic          clk_os = 1'b0;
   logic          reset_os;
   logic          i_start;
   logic          i_pixel_valid;
   logic [DW-1:0] i_pixel_data;
   logic          o_pixel_ready;
   logic          o_wen;
   logic [DW-1:0] o_fifo_in;
   logic [CW-1:0] o_col_index;
   logic [RW-1:0] o_row_index;
   logic          o_end_of_row;
   logic          o_busy;
   logic          o_frame_done;
`ifdef INTEGRAL_ROW_FEEDER_ABORT_EN
   logic          i_abort;
   logic          o_aborted;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk_os = ~clk_os;

   integral_row_feeder #(
      .DATA_WIDTH  (DW),
      .FRAME_WIDTH (FW),
      .FRAME_HEIGHT(FH),
      .COL_WIDTH   (CW),
      .ROW_WIDTH   (RW),
      .FLUSH_COUNT (FC)
   ) dut (
      .clk_os       (clk_os),
      .reset_os     (reset_os),
      .i_start      (i_start),
      .i_pixel_valid(i_pixel_valid),
      .i_pixel_data (i_pixel_data),
      .o_pixel_ready(o_pixel_ready),
      .o_wen        (o_wen),
      .o_fifo_in    (o_fifo_in),
      .o_col_index  (o_col_index),
      .o_row_index  (o_row_index),
      .o_end_of_row (o_end_of_row),
      .o_busy       (o_busy),
`ifdef INTEGRAL_ROW_FEEDER_ABORT_EN
      .i_abort      (i_abort),
      .o_aborted    (o_aborted),
`endif
      .o_frame_done (o_frame_done)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_ready"}, o_pixel_ready, 0);
      check_val({tag, "_wen"},   o_wen, 0);
      check_val({tag, "_data"},  o_fifo_in, 0);
      check_val({tag, "_col"},   o_col_index, 0);
      check_val({tag, "_row"},   o_row_index, 0);
      check_val({tag, "_eor"},   o_end_of_row, 0);
      check_val({tag, "_busy"},  o_busy, 0);
      check_val({tag, "_done"},  o_frame_done, 0);
   endtask

   // mode 0: valid always high, data 1..N; mode 1: valid alternates; mode 2: random valid/data.
   task automatic run_frame(input int mode, input bit restart_mid, input bit rst_in_flush,
                            input int abort_at);
      wr_t exp_q[$];
      wr_t obs_q[$];
      int  acc_cyc[$];
      int  wr_cyc[$];
      int  n_acc = 0;
      int  cyc = 0;
      int  done_cnt = 0;
      int  done_cyc = -1;
      int  ab_cnt = 0;
      int  ab_cyc = -1;
      int  exp_ab_cyc = -1;
      bit  started = 0;
      bit  restarted = 0;
      bit  exp_ready;
      bit  acc;
      int  n;
      forever begin
         @(negedge clk_os);
         if (o_wen) begin
            obs_q.push_back('{o_fifo_in, int'(o_col_index), int'(o_row_index), o_end_of_row});
            wr_cyc.push_back(cyc);
         end
         if (o_frame_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
`ifdef INTEGRAL_ROW_FEEDER_ABORT_EN
         if (o_aborted) begin
            ab_cnt++;
            ab_cyc = cyc;
         end
`endif
         exp_ready = started && (n_acc < NPIX);
         check_val("ready", o_pixel_ready, exp_ready);
         if (exp_ready) check_val("busy_feed", o_busy, 1);

         if (rst_in_flush && obs_q.size() == NPIX + 1) begin
            #2 reset_os = 1'b1;
            #1;
            check_all_zero("rst_async");
            i_start = 1'b0;
            @(negedge clk_os);
            reset_os = 1'b0;
            repeat (10) begin
               @(negedge clk_os);
               check_val("post_rst_done", o_frame_done, 0);
               check_val("post_rst_wen", o_wen, 0);
            end
            return;
         end

         i_start = (cyc == 0);
         if (restart_mid && !restarted && n_acc == 3) begin
            i_start   = 1'b1;
            restarted = 1'b1;
         end
         case (mode)
            0:       i_pixel_valid = 1'b1;
            1:       i_pixel_valid = (cyc % 2 == 1);
            default: i_pixel_valid = 1'($urandom_range(0, 1));
         endcase
         if (mode == 2) i_pixel_data = DW'($urandom);
         else           i_pixel_data = DW'(n_acc + 1);
`ifdef INTEGRAL_ROW_FEEDER_ABORT_EN
         i_abort = 1'b0;
`endif
         acc = i_pixel_valid && exp_ready;
         if (acc && abort_at >= 0 && n_acc == abort_at) begin
`ifdef INTEGRAL_ROW_FEEDER_ABORT_EN
            i_abort = 1'b1;
`endif
            exp_ab_cyc = cyc + 1;
            started    = 1'b0;
         end else if (acc) begin
            exp_q.push_back('{i_pixel_data, n_acc % FW, n_acc / FW, (n_acc % FW) == FW - 1});
            acc_cyc.push_back(cyc);
            n_acc++;
            if (n_acc == NPIX) begin
               for (int j = 0; j < FC; j++) exp_q.push_back('{DW'(0), FW - 1, FH - 1, 1'b0});
            end
         end
         if (cyc == 0) started = 1'b1;
         cyc++;
         if (done_cnt > 0 && cyc > done_cyc + 3) break;
         if (exp_ab_cyc >= 0 && cyc > exp_ab_cyc + 4) break;
         if (cyc >= BUDGET) begin
            check_val("timeout", cyc, 0);
            break;
         end
      end

      check_val("n_writes", obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check_val("wr_data", obs_q[i].d, exp_q[i].d);
         check_val("wr_col",  obs_q[i].c, exp_q[i].c);
         check_val("wr_row",  obs_q[i].r, exp_q[i].r);
         check_val("wr_eor",  obs_q[i].e, exp_q[i].e);
      end
      n = (wr_cyc.size() < acc_cyc.size()) ? wr_cyc.size() : acc_cyc.size();
      for (int i = 0; i < n; i++) check_val("wr_latency", wr_cyc[i], acc_cyc[i] + 1);

      if (abort_at < 0) begin
         check_val("done_count", done_cnt, 1);
         for (int j = 0; j < FC; j++) begin
            if (NPIX + j < wr_cyc.size())
               check_val("flush_gap", wr_cyc[NPIX + j], wr_cyc[NPIX - 1] + 1 + j);
         end
         if (wr_cyc.size() > 0) check_val("done_cycle", done_cyc, wr_cyc[wr_cyc.size() - 1] + 1);
      end else begin
         check_val("abort_done_count", done_cnt, 0);
         check_val("abort_pulses", ab_cnt, 1);
         check_val("abort_cycle", ab_cyc, exp_ab_cyc);
      end
   endtask

   initial begin
      reset_os      = 1'b1;
      i_start       = 1'b0;
      i_pixel_valid = 1'b0;
      i_pixel_data  = '0;
`ifdef INTEGRAL_ROW_FEEDER_ABORT_EN
      i_abort       = 1'b0;
`endif
      repeat (2) @(negedge clk_os);
      check_all_zero("reset");
      reset_os      = 1'b0;
      i_pixel_valid = 1'b1;
      repeat (20) begin
         @(negedge clk_os);
         check_val("idle_ready", o_pixel_ready, 0);
         check_val("idle_wen", o_wen, 0);
      end

      run_frame(0, 1'b0, 1'b0, -1);
      run_frame(1, 1'b0, 1'b0, -1);
      run_frame(0, 1'b1, 1'b0, -1);
      run_frame(2, 1'b0, 1'b1, -1);
      run_frame(0, 1'b0, 1'b0, -1);
      repeat (3) run_frame(2, 1'b0, 1'b0, -1);
`ifdef INTEGRAL_ROW_FEEDER_ABORT_EN
      run_frame(0, 1'b0, 1'b0, 4);
      run_frame(2, 1'b0, 1'b0, -1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
